// File: rtl/branch_pred_table.sv
// branch_pred_table: direct-mapped branch target buffer with saturating direction counters,
// same-cycle lookup, one-cycle update, and mispredict/lookup statistics.
module branch_pred_table #(
  parameter int ENTRIES  = 16,
  parameter int CTR_BITS = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] fetch_pc,
  output logic        hit,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        update_en,
  input  logic [31:0] update_pc,
  input  logic        update_taken,
  input  logic [31:0] update_target,
  input  logic        update_pred,
  input  logic [31:0] update_pred_target,
  output logic        flush,
  output logic [31:0] lookups,
  output logic [31:0] mispredicts
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(1 << (CTR_BITS - 1));
  localparam logic [CTR_BITS-1:0] CTR_RST  = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]    tag_q [ENTRIES];
  logic [29:0]         tgt_q [ENTRIES];
  logic [CTR_BITS-1:0] ctr_q [ENTRIES];
  logic [IDX_W-1:0] f_idx, u_idx;
  logic [TAG_W-1:0] f_tag, u_tag;
  logic             u_hit;
  logic [CTR_BITS-1:0] u_ctr;
  logic             unused_pc_bits;
  assign unused_pc_bits = ^{fetch_pc[1:0], update_pc[1:0], update_target[1:0]};
  always_comb begin
    f_idx       = fetch_pc[IDX_W+1:2];
    f_tag       = fetch_pc[31:IDX_W+2];
    u_idx       = update_pc[IDX_W+1:2];
    u_tag       = update_pc[31:IDX_W+2];
    hit         = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    pred_taken  = hit && ctr_q[f_idx][CTR_BITS-1];
    pred_target = pred_taken ? {tgt_q[f_idx], 2'b00} : fetch_pc + 32'd4;
    u_hit       = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    u_ctr       = ctr_q[u_idx];
    flush       = update_en && ((update_taken != update_pred) ||
                                (update_taken && (update_target != update_pred_target)));
  end
  // Hits train the counter in place; taken misses evict whatever shares the index.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q     <= '0;
      lookups     <= '0;
      mispredicts <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        ctr_q[i] <= CTR_RST;
      end
    end else begin
      if (update_en && u_hit) begin
        ctr_q[u_idx] <= update_taken ? ((u_ctr == CTR_MAX) ? u_ctr : u_ctr + 1'b1)
                                     : ((u_ctr == '0) ? u_ctr : u_ctr - 1'b1);
        if (update_taken) tgt_q[u_idx] <= update_target[31:2];
      end else if (update_en && update_taken) begin
        valid_q[u_idx] <= 1'b1;
        tag_q[u_idx]   <= u_tag;
        tgt_q[u_idx]   <= update_target[31:2];
        ctr_q[u_idx]   <= CTR_INIT;
      end
      if (update_en && lookups != '1) lookups <= lookups + 32'd1;
      if (flush && mispredicts != '1) mispredicts <= mispredicts + 32'd1;
    end
  end
endmodule

// File: tb/tb_branch_pred_table.sv
// tb_branch_pred_table: directed scenarios plus randomized traffic checked against
// an arithmetic table model of the predictor.
module tb_branch_pred_table;
  localparam int EN = 16;
  localparam int CB = 2;
  localparam int IW = 4;
  localparam int CMAX = (1 << CB) - 1;
  logic        CLK, nRST;
  logic [31:0] fetch_pc;
  logic        hit, pred_taken;
  logic [31:0] pred_target;
  logic        update_en, update_taken, update_pred;
  logic [31:0] update_pc, update_target, update_pred_target;
  logic        flush;
  logic [31:0] lookups, mispredicts;
  int total = 0;
  int bad = 0;
  bit          m_valid [EN];
  logic [31:0] m_tag [EN];
  logic [31:0] m_tgt [EN];
  int          m_ctr [EN];
  int          m_lookups, m_misp;

  branch_pred_table #(.ENTRIES(EN), .CTR_BITS(CB)) dut (
    .CLK(CLK), .nRST(nRST), .fetch_pc(fetch_pc), .hit(hit), .pred_taken(pred_taken),
    .pred_target(pred_target), .update_en(update_en), .update_pc(update_pc),
    .update_taken(update_taken), .update_target(update_target), .update_pred(update_pred),
    .update_pred_target(update_pred_target), .flush(flush), .lookups(lookups),
    .mispredicts(mispredicts)
  );

  initial CLK = 0;
  always #5 CLK = ~CLK;

  task automatic mreset();
    for (int i = 0; i < EN; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = (1 << (CB - 1)) - 1;
    end
    m_lookups = 0; m_misp = 0;
  endtask

  function automatic void mpred(input logic [31:0] pc, output logic h, output logic t,
                                output logic [31:0] tg);
    int unsigned i = (pc >> 2) % EN;
    h  = m_valid[i] && (m_tag[i] == (pc >> (2 + IW)));
    t  = h && (m_ctr[i] >= (1 << (CB - 1)));
    tg = t ? m_tgt[i] : pc + 32'd4;
  endfunction

  function automatic logic mflush();
    return update_en && ((update_taken != update_pred) ||
                         (update_taken && update_target != update_pred_target));
  endfunction

  // Advance one clock edge, applying the held update to the model like the DUT does.
  task automatic tick();
    int unsigned i;
    logic [31:0] t;
    @(posedge CLK);
    if (nRST && update_en) begin
      i = (update_pc >> 2) % EN;
      t = update_pc >> (2 + IW);
      if (m_valid[i] && m_tag[i] == t) begin
        if (update_taken) begin
          m_ctr[i] = (m_ctr[i] < CMAX) ? m_ctr[i] + 1 : CMAX;
          m_tgt[i] = update_target & ~32'd3;
        end else m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
      end else if (update_taken) begin
        m_valid[i] = 1; m_tag[i] = t; m_tgt[i] = update_target & ~32'd3; m_ctr[i] = 1 << (CB - 1);
      end
      if (m_lookups != -1) m_lookups++;
      if (mflush() && m_misp != -1) m_misp++;
    end
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tg,
                     input logic pr, input logic [31:0] ptg);
    update_en = 1; update_pc = pc; update_taken = tk; update_target = tg;
    update_pred = pr; update_pred_target = ptg;
  endtask

  task automatic idle();
    update_en = 0; update_pc = 0; update_taken = 0; update_target = 0;
    update_pred = 0; update_pred_target = 0;
  endtask

  task automatic test_reset();
    nRST = 0; fetch_pc = 32'h40; idle(); mreset();
    #1;
    total++;
    if (hit !== 1'b0 || pred_taken !== 1'b0 || pred_target !== 32'h44) begin
      bad++; $display("FAIL reset_lookup: hit=%b taken=%b target=%h want 0 0 00000044", hit, pred_taken, pred_target);
    end
    total++;
    if (lookups !== 32'd0 || mispredicts !== 32'd0) begin
      bad++; $display("FAIL reset_counts: lookups=%0d mispredicts=%0d want 0 0", lookups, mispredicts);
    end
    upd(32'h40, 1, 32'h100, 0, 0);
    #1;
    total++;
    if (flush !== 1'b1) begin bad++; $display("FAIL reset_flush: got %b want 1", flush); end
    tick(); tick();
    total++;
    if (hit !== 1'b0 || lookups !== 32'd0) begin
      bad++; $display("FAIL reset_no_update: hit=%b lookups=%0d want 0 0", hit, lookups);
    end
    idle(); nRST = 1; tick();
  endtask

  task automatic test_cold_miss();
    fetch_pc = 32'h40;
    upd(32'h40, 1, 32'h100, 0, 0);
    #1;
    total++;
    if (flush !== 1'b1 || hit !== 1'b0) begin
      bad++; $display("FAIL cold_flush: flush=%b hit=%b want 1 0", flush, hit);
    end
    tick(); idle(); #1;
    total++;
    if (hit !== 1'b1 || pred_taken !== 1'b1 || pred_target !== 32'h100) begin
      bad++; $display("FAIL cold_retrain: hit=%b taken=%b target=%h want 1 1 00000100", hit, pred_taken, pred_target);
    end
    total++;
    if (mispredicts !== 32'd1 || lookups !== 32'd1) begin
      bad++; $display("FAIL cold_counts: mispredicts=%0d lookups=%0d want 1 1", mispredicts, lookups);
    end
  endtask

  task automatic test_saturation();
    logic [8:0] seq = 9'b110000111;
    logic [8:0] exp = 9'b100001111;
    logic h, t;
    logic [31:0] tg;
    fetch_pc = 32'h40;
    for (int k = 0; k < 9; k++) begin
      mpred(32'h40, h, t, tg);
      upd(32'h40, seq[k], 32'h100, t, tg);
      tick(); idle(); #1;
      total++;
      if (pred_taken !== exp[k] || hit !== 1'b1) begin
        bad++; $display("FAIL saturation step %0d: taken=%b hit=%b want %b 1", k, pred_taken, hit, exp[k]);
      end
    end
  endtask

  task automatic test_alias();
    upd(32'h80, 1, 32'h300, 0, 0);
    tick(); idle();
    fetch_pc = 32'h40; #1;
    total++;
    if (hit !== 1'b0) begin bad++; $display("FAIL alias_evicted: hit=%b want 0", hit); end
    fetch_pc = 32'h80; #1;
    total++;
    if (hit !== 1'b1 || pred_taken !== 1'b1 || pred_target !== 32'h300) begin
      bad++; $display("FAIL alias_new: hit=%b taken=%b target=%h want 1 1 00000300", hit, pred_taken, pred_target);
    end
  endtask

  task automatic test_wrong_target();
    fetch_pc = 32'h40;
    upd(32'h40, 1, 32'h100, 0, 0);
    tick();
    upd(32'h40, 1, 32'h200, 1, 32'h100);
    #1;
    total++;
    if (flush !== 1'b1) begin bad++; $display("FAIL wrong_target_flush: got %b want 1", flush); end
    tick(); idle(); #1;
    total++;
    if (pred_target !== 32'h200) begin
      bad++; $display("FAIL wrong_target_retarget: got %h want 00000200", pred_target);
    end
    upd(32'h40, 1, 32'h200, 1, 32'h200);
    #1;
    total++;
    if (flush !== 1'b0) begin bad++; $display("FAIL correct_no_flush: got %b want 0", flush); end
    tick(); idle();
  endtask

  task automatic test_wrap();
    fetch_pc = 32'hFFFF_FFFC; #1;
    total++;
    if (hit !== 1'b0 || pred_target !== 32'h0) begin
      bad++; $display("FAIL wrap_pc4: hit=%b target=%h want 0 00000000", hit, pred_target);
    end
    upd(32'hFFFF_FFFC, 1, 32'h1234, 0, 0);
    tick(); idle(); #1;
    total++;
    if (hit !== 1'b1 || pred_target !== 32'h1234) begin
      bad++; $display("FAIL wrap_alloc: hit=%b target=%h want 1 00001234", hit, pred_target);
    end
  endtask

  task automatic test_bypass_reset();
    fetch_pc = 32'h40;
    upd(32'h40, 1, 32'h500, 1, 32'h200);
    #1;
    total++;
    if (pred_target !== 32'h200 || pred_taken !== 1'b1) begin
      bad++; $display("FAIL bypass_old: target=%h taken=%b want 00000200 1", pred_target, pred_taken);
    end
    tick(); #1;
    total++;
    if (pred_target !== 32'h500) begin bad++; $display("FAIL bypass_new: got %h want 00000500", pred_target); end
    #1; nRST = 0; mreset(); #1;
    total++;
    if (hit !== 1'b0 || lookups !== 32'd0 || mispredicts !== 32'd0) begin
      bad++; $display("FAIL async_reset: hit=%b lookups=%0d mispredicts=%0d want 0 0 0", hit, lookups, mispredicts);
    end
    tick(); nRST = 1;
    upd(32'h40, 1, 32'h600, 0, 0);
    tick(); idle(); #1;
    total++;
    if (hit !== 1'b1 || pred_target !== 32'h600 || lookups !== 32'd1) begin
      bad++; $display("FAIL post_release: hit=%b target=%h lookups=%0d want 1 00000600 1", hit, pred_target, lookups);
    end
  endtask

  task automatic test_random();
    logic h, t;
    logic [31:0] tg, pc;
    for (int k = 0; k < 400; k++) begin
      fetch_pc = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 63) << 2;
      if ($urandom_range(0, 3) != 0) begin
        pc = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 63) << 2;
        mpred(pc, h, t, tg);
        if ($urandom_range(0, 3) == 0) begin t = $urandom_range(0, 1); tg = $urandom; end
        upd(pc, $urandom_range(0, 1), ($urandom_range(0, 1) ? tg : $urandom), t, tg);
      end else idle();
      #1;
      mpred(fetch_pc, h, t, tg);
      total++;
      if (hit !== h || pred_taken !== t || pred_target !== tg || flush !== mflush()) begin
        bad++;
        $display("FAIL random_lookup %0d: hit=%b taken=%b target=%h flush=%b want %b %b %h %b",
                 k, hit, pred_taken, pred_target, flush, h, t, tg, mflush());
      end
      tick();
      total++;
      if (lookups !== m_lookups || mispredicts !== m_misp) begin
        bad++; $display("FAIL random_counts %0d: lookups=%0d mispredicts=%0d want %0d %0d",
                        k, lookups, mispredicts, m_lookups, m_misp);
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_saturation();
    test_alias();
    test_wrong_target();
    test_wrap();
    test_bypass_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
